instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the immediate generator and decoder in the RISC-V core.
- Owns the program counter and issues one word request at a time to instruction memory, which has variable latency.
- Holds each returned instruction in a single-entry output buffer until decode accepts it.
- Accepts redirects (branch/jal/jalr targets computed downstream) and discards any in-flight stale fetch.

---
 rtl/instruction_fetch_unit_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit_pc_reg.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 tb/tb_instruction_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its PC register.
package instruction_fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory request/response, decode handoff and redirect.
interface instruction_fetch_unit_if #(parameter int XLEN = 32);

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_valid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic            instr_valid_o;
    logic            dec_ready_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            misalign_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, misalign_o,
        input  imem_valid_i, imem_rdata_i, dec_ready_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, misalign_o,
        output imem_valid_i, imem_rdata_i, dec_ready_i, redirect_i, redirect_pc_i
    );

endinterface

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter: +4 step, word-aligned redirect load, misalignment flag.
// Latency: new PC visible one cycle after inc_en/redirect_en; misalign is combinational.
// Backpressure: none; the fetch FSM decides when the PC may advance.
module fetch_pc_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_en,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        misalign
);

    // Redirect outranks the sequential step; low address bits are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect_en) begin
            pc <= align_word(redirect_pc);
        end else if (inc_en) begin
            pc <= pc + PC_STEP;
        end
    end

    assign misalign = redirect_en && (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding imem word request, single-entry instruction buffer to decode.
// Latency: REQ -> WAIT (memory latency) -> HOLD, so at least 3 cycles per instruction.
// Backpressure: buffer is held while dec_ready_i=0; no new request until decode accepts.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            redirect_en;
    logic            inc_en;
    logic            load_buf;

    assign redirect_en = bus.redirect_i && (state_q != S_IDLE);
    assign inc_en      = (state_q == S_HOLD) && bus.dec_ready_i && !bus.redirect_i;
    assign load_buf    = (state_q == S_WAIT) && bus.imem_valid_i && !bus.redirect_i;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .inc_en      (inc_en),
        .redirect_en (redirect_en),
        .redirect_pc (bus.redirect_pc_i),
        .pc          (pc),
        .misalign    (bus.misalign_o)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = bus.redirect_i ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (bus.imem_valid_i) begin
                    state_d = bus.redirect_i ? S_REQ : S_HOLD;
                end else if (bus.redirect_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (bus.redirect_i || bus.dec_ready_i) begin
                    state_d = S_REQ;
                end
            end
            // A redirect here only retargets the PC; the stale response is still owed.
            S_DRAIN: begin
                if (bus.imem_valid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (redirect_en) begin
            valid_q <= 1'b0;
        end else if (load_buf) begin
            instr_q <= bus.imem_rdata_i;
            pc_q    <= pc;
            valid_q <= 1'b1;
        end else if (inc_en) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.imem_req_o    = (state_q == S_REQ);
    assign bus.imem_addr_o   = (state_q == S_REQ) ? pc : '0;
    assign bus.instr_o       = instr_q;
    assign bus.pc_o          = pc_q;
    assign bus.instr_valid_o = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: variable-latency memory model plus request/consume scoreboards.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          c;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat = 1;
    logic pend = 1'b0;
    int   cnt = 0;
    logic [31:0] paddr = '0;
    logic wpend = 1'b0;

    req_t        req_log[$];
    out_t        cons_log[$];
    out_t        exp_q[$];
    logic [31:0] w_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instruction_fetch_unit_if #(.XLEN(32)) bus ();
    instruction_fetch_unit_if #(.XLEN(32)) wbus ();

    instruction_fetch_unit #(.RESET_PC(32'h0040_0000), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut_wrap (
        .clk(clk), .reset(reset), .bus(wbus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h0050_0093;
        return a ^ 32'hA5A5_0003;
    endfunction

    // Memory model for the main DUT: one outstanding request, response after 'lat' cycles.
    always @(negedge clk) begin
        bus.imem_valid_i = 1'b0;
        if (!reset) begin
            pend = 1'b0;
            bus.imem_rdata_i = '0;
        end else begin
            if (bus.imem_req_o) begin
                checks++;
                if (pend) begin
                    errors++;
                    $display("FAIL req_while_outstanding: req=1 at cycle %0d, required 0", cyc);
                end
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_valid_i = 1'b1;
                    bus.imem_rdata_i = mem_word(paddr);
                    pend = 1'b0;
                end
            end
            if (bus.imem_req_o) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = bus.imem_addr_o;
                req_log.push_back('{bus.imem_addr_o, cyc});
            end
            if (bus.instr_valid_o && bus.dec_ready_i) cons_log.push_back('{bus.pc_o, bus.instr_o});
        end
    end

    always @(negedge clk) begin
        wbus.imem_valid_i = wpend && reset;
        wbus.imem_rdata_i = NOP_INSTR;
        wpend = reset && wbus.imem_req_o;
        if (reset && wbus.imem_req_o) w_log.push_back(wbus.imem_addr_o);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_req(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req_log.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_cons(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cons_log.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.instr_valid_o) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic ready);
        bus.dec_ready_i   = ready;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = target;
        req_log.delete();
        cons_log.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks += 6;
        if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
        if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr_o); end
        if (bus.instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", bus.instr_o); end
        if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.pc_o); end
        if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid_o); end
        if (bus.misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", bus.misalign_o); end
    endtask

    task automatic test_stream();
        bit ok;
        logic [31:0] a;
        out_t o, e;
        lat = 1;
        bus.dec_ready_i = 1'b1;
        req_log.delete();
        cons_log.delete();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h0040_0000 + 32'(4 * i);
            exp_q.push_back('{a, mem_word(a)});
        end
        wait_req(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_req_timeout: got %0d reqs want 3", req_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (req_log[i].addr !== 32'h0040_0000 + 32'(4 * i)) begin
                    errors++; $display("FAIL stream_addr%0d: got %h want %h", i, req_log[i].addr, 32'h0040_0000 + 32'(4 * i));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (req_log[i].c - req_log[i-1].c != 3) begin
                    errors++; $display("FAIL stream_spacing%0d: got %0d cycles want 3", i, req_log[i].c - req_log[i-1].c);
                end
            end
        end
        wait_cons(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_cons_timeout: got %0d want 3", cons_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                o = cons_log.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (o.pc !== e.pc || o.instr !== e.instr) begin
                    errors++; $display("FAIL stream_out%0d: got pc=%h instr=%h want pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40 && w_log.size() < 2; i++) tick();
        checks++;
        if (w_log.size() < 2) begin errors++; $display("FAIL wrap_timeout: got %0d reqs want 2", w_log.size()); end
        else begin
            checks += 2;
            if (w_log[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h want fffffffc", w_log[0]); end
            if (w_log[1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_second: got %h want 00000000", w_log[1]); end
        end
    endtask

    task automatic test_hold_stall();
        bit ok;
        tick();
        do_redirect(32'h0040_0000, 1'b0);
        tick();
        bus.redirect_i = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_valid_timeout: instr_valid_o got 0 want 1"); end
        else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (bus.instr_o !== 32'h0050_0093 || bus.pc_o !== 32'h0040_0000 || bus.instr_valid_o !== 1'b1) begin
                    errors++; $display("FAIL hold_stable%0d: got instr=%h pc=%h v=%b want 00500093/00400000/1", k, bus.instr_o, bus.pc_o, bus.instr_valid_o);
                end
                tick();
            end
            checks++;
            if (req_log.size() != 1) begin errors++; $display("FAIL hold_no_req: got %0d reqs want 1", req_log.size()); end
            bus.dec_ready_i = 1'b1;
            wait_req(2, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL hold_next_timeout: got %0d reqs want 2", req_log.size()); end
            else if (req_log[1].addr !== 32'h0040_0004) begin
                errors++; $display("FAIL hold_next_addr: got %h want 00400004", req_log[1].addr);
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        int n0;
        lat = 4;
        bus.dec_ready_i = 1'b1;
        tick();
        n0 = req_log.size();
        for (int i = 0; i < 40 && req_log.size() <= n0; i++) tick();
        tick();
        exp_q.push_back('{32'h0040_0100, mem_word(32'h0040_0100)});
        do_redirect(32'h0040_0100, 1'b1);
        tick();
        bus.redirect_i = 1'b0;
        wait_req(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rdw_req_timeout: no request after redirect"); end
        else if (req_log[0].addr !== 32'h0040_0100) begin
            errors++; $display("FAIL rdw_addr: got %h want 00400100", req_log[0].addr);
        end
        wait_cons(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rdw_cons_timeout: no instruction after redirect"); end
        else if (cons_log[0].pc !== exp_q[0].pc || cons_log[0].instr !== exp_q[0].instr) begin
            errors++; $display("FAIL rdw_out: got pc=%h instr=%h want pc=%h instr=%h", cons_log[0].pc, cons_log[0].instr, exp_q[0].pc, exp_q[0].instr);
        end
        exp_q.delete();
        lat = 1;
    endtask

    task automatic test_misalign();
        bit ok;
        tick();
        do_redirect(32'h0040_0102, 1'b1);
        #1;
        checks++;
        if (bus.misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b want 1", bus.misalign_o); end
        tick();
        bus.redirect_i = 1'b0;
        #1;
        checks++;
        if (bus.misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b want 0", bus.misalign_o); end
        wait_req(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL misalign_req_timeout: no request"); end
        else if (req_log[0].addr !== 32'h0040_0100) begin
            errors++; $display("FAIL misalign_addr: got %h want 00400100", req_log[0].addr);
        end
    endtask

    task automatic test_redirect_hold_ready();
        bit ok;
        tick();
        do_redirect(32'h0040_0010, 1'b0);
        tick();
        bus.redirect_i = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || bus.pc_o !== 32'h0040_0010) begin
            errors++; $display("FAIL rhr_setup: got v=%b pc=%h want 1/00400010", bus.instr_valid_o, bus.pc_o);
        end
        do_redirect(32'h0040_0040, 1'b1);
        tick();
        bus.redirect_i = 1'b0;
        wait_req(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rhr_req_timeout: no request"); end
        else if (req_log[0].addr !== 32'h0040_0040) begin
            errors++; $display("FAIL rhr_addr: got %h want 00400040", req_log[0].addr);
        end
        wait_cons(1, ok);
        checks++;
        if (!ok || cons_log[0].pc !== 32'h0040_0040) begin
            errors++; $display("FAIL rhr_out: got ok=%b pc=%h want pc=00400040", ok, ok ? cons_log[0].pc : 32'h0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        int n0;
        lat = 4;
        tick();
        n0 = req_log.size();
        for (int i = 0; i < 40 && req_log.size() <= n0; i++) tick();
        tick();
        reset = 1'b0;
        #1;
        checks += 5;
        if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", bus.imem_req_o); end
        if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rmid_addr: got %h want 0", bus.imem_addr_o); end
        if (bus.instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rmid_instr: got %h want 00000013", bus.instr_o); end
        if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL rmid_pc: got %h want 0", bus.pc_o); end
        if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.instr_valid_o); end
        tick();
        tick();
        lat = 1;
        req_log.delete();
        cons_log.delete();
        reset = 1'b1;
        wait_req(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_restart_timeout: no request"); end
        else if (req_log[0].addr !== 32'h0040_0000) begin
            errors++; $display("FAIL rmid_restart_addr: got %h want 00400000", req_log[0].addr);
        end
    endtask

    initial begin
        bus.dec_ready_i    = 1'b0;
        bus.redirect_i     = 1'b0;
        bus.redirect_pc_i  = '0;
        wbus.dec_ready_i   = 1'b1;
        wbus.redirect_i    = 1'b0;
        wbus.redirect_pc_i = '0;
        test_reset();
        test_stream();
        test_wrap();
        test_hold_stall();
        test_redirect_wait();
        test_misalign();
        test_redirect_hold_ready();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
